// File: rtl/adder_nbit_reg_if.sv
// ============================================================================
// adder_nbit_reg_if : operand/result bundle for adder_nbit_reg
// Rev 1.0
// ============================================================================
`default_nettype none

interface adder_nbit_reg_if #(
  parameter int N = 3
);
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic [N:0]   sum;

  modport master (
    output in_valid, a, b,
    input  out_valid, sum
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum
  );
endinterface

`default_nettype wire

// File: rtl/adder_nbit_reg.sv
// ============================================================================
// adder_nbit_reg : unsigned N-bit adder, full-precision N+1-bit registered sum
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_nbit_reg #(
  parameter int N       = 3,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_nbit_reg_if.slave  bus
);

  logic [N:0]         add_result;
  logic [LATENCY-1:0] stage_valid;
  logic [N:0]         stage_sum [LATENCY];

  assign add_result = {1'b0, bus.a} + {1'b0, bus.b};

  // Data only loads on a valid sample so X operands never reach the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid[0] <= 1'b0;
      stage_sum[0]   <= '0;
    end else begin
      stage_valid[0] <= bus.in_valid;
      if (bus.in_valid) begin
        stage_sum[0] <= add_result;
      end
    end
  end

  generate
    for (genvar k = 1; k < LATENCY; k++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_valid[k] <= 1'b0;
          stage_sum[k]   <= '0;
        end else begin
          stage_valid[k] <= stage_valid[k-1];
          stage_sum[k]   <= stage_sum[k-1];
        end
      end
    end
  endgenerate

  assign bus.out_valid = stage_valid[LATENCY-1];
  assign bus.sum       = stage_sum[LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_adder_nbit_reg.sv
// ============================================================================
// tb_adder_nbit_reg : directed self-checking bench for adder_nbit_reg
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_nbit_reg;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  adder_nbit_reg_if #(.N(10)) bus   ();
  adder_nbit_reg_if #(.N(10)) bus3  ();
  adder_nbit_reg_if #(.N(3))  bus_s ();

  adder_nbit_reg #(.N(10), .LATENCY(1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  adder_nbit_reg #(.N(10), .LATENCY(3)) dut3  (.clk(clk), .rst_n(rst_n), .bus(bus3));
  adder_nbit_reg #(.N(3),  .LATENCY(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.a = '0; bus.b = '0;
    bus3.in_valid = 0; bus3.a = '0; bus3.b = '0;
    bus_s.in_valid = 0; bus_s.a = '0; bus_s.b = '0;
    rst_n = 0;
    #3;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 11'd0) begin
      fails++;
      $display("FAIL reset_now: valid=%0b sum=%0d, expected 0/0", bus.out_valid, bus.sum);
    end
    tick(); tick();
    tests++;
    if (bus3.out_valid !== 1'b0 || bus3.sum !== 11'd0 || bus_s.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_l3: valid=%0b sum=%0d, expected 0/0", bus3.out_valid, bus3.sum);
    end
    rst_n = 1;
    bus.a = 10'd0; bus.b = 10'd0; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 11'd0) begin
      fails++;
      $display("FAIL first_zero: valid=%0b sum=%0d, expected 1/0", bus.out_valid, bus.sum);
    end
  endtask

  task automatic test_back_to_back();
    int av [3] = '{1, 33, 100};
    int bv [3] = '{99, 47, 47};
    int ev [3] = '{100, 80, 147};
    for (int i = 0; i < 3; i++) begin
      bus.a = 10'(av[i]); bus.b = 10'(bv[i]); bus.in_valid = 1;
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.sum !== 11'(ev[i])) begin
        fails++;
        $display("FAIL seq%0d: valid=%0b sum=%0d, expected 1/%0d", i, bus.out_valid, bus.sum, ev[i]);
      end
    end
    bus.in_valid = 0;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin bus.a = 'x; bus.b = 'x; end
      else begin bus.a = 10'(i * 300); bus.b = 10'(1023 - i); end
      tick();
      tests++;
      if (bus.out_valid !== 1'b0 || bus.sum !== 11'd147) begin
        fails++;
        $display("FAIL hold%0d: valid=%0b sum=%0d, expected 0/147", i, bus.out_valid, bus.sum);
      end
    end
  endtask

  task automatic test_carry();
    bus.a = 10'd1023; bus.b = 10'd1023; bus.in_valid = 1;
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 11'd2046 || bus.sum[10] !== 1'b1) begin
      fails++;
      $display("FAIL carry_max: valid=%0b sum=%0d, expected 1/2046", bus.out_valid, bus.sum);
    end
    bus.a = 10'd512; bus.b = 10'd512;
    tick();
    bus.in_valid = 0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 11'd1024) begin
      fails++;
      $display("FAIL carry_512: valid=%0b sum=%0d, expected 1/1024", bus.out_valid, bus.sum);
    end
    // Reset between edges must clear the held sum without waiting for clk.
    #2 rst_n = 0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 11'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%0b sum=%0d, expected 0/0", bus.out_valid, bus.sum);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [10:0] exp_sum = 11'd0;
    logic        v;
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 3) != 0);
      bus.a = 10'($urandom); bus.b = 10'($urandom); bus.in_valid = v;
      if (v) exp_sum = {1'b0, bus.a} + {1'b0, bus.b};
      tick();
      tests++;
      if (bus.out_valid !== v || bus.sum !== exp_sum) begin
        fails++;
        $display("FAIL rand%0d: valid=%0b sum=%0d, expected %0b/%0d", i, bus.out_valid, bus.sum, v, exp_sum);
      end
    end
    bus.in_valid = 0;
  endtask

  task automatic test_latency3();
    logic [2:0] ev = 3'b100;
    bus3.a = 10'd33; bus3.b = 10'd47; bus3.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus3.in_valid = 0;
      tests++;
      if (bus3.out_valid !== (i == 2) || (i >= 2 && bus3.sum !== 11'd80)) begin
        fails++;
        $display("FAIL lat3_edge%0d: valid=%0b sum=%0d, expected %0b/80", i, bus3.out_valid, bus3.sum, ev[i%3] && i == 2);
      end
    end
    // Second pair is in flight when reset hits; it must never surface.
    bus3.a = 10'd100; bus3.b = 10'd47; bus3.in_valid = 1;
    tick();
    bus3.in_valid = 0;
    tick();
    rst_n = 0;
    #1;
    tests++;
    if (bus3.out_valid !== 1'b0 || bus3.sum !== 11'd0) begin
      fails++;
      $display("FAIL lat3_rst: valid=%0b sum=%0d, expected 0/0", bus3.out_valid, bus3.sum);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (bus3.out_valid !== 1'b0 || bus3.sum !== 11'd0) begin
        fails++;
        $display("FAIL lat3_flush%0d: valid=%0b sum=%0d, expected 0/0", i, bus3.out_valid, bus3.sum);
      end
    end
  endtask

  task automatic test_exhaustive_n3();
    logic       dv [66];
    logic [3:0] ds [66];
    logic [3:0] held = 4'd0;
    for (int c = 0; c < 66; c++) begin
      dv[c] = (c < 64) && ((c % 7) != 3);
      bus_s.a = 3'(c >> 3); bus_s.b = 3'(c); bus_s.in_valid = dv[c];
      ds[c] = 4'(c >> 3 & 7) + 4'(c & 7);
      tick();
      if (c >= 1) begin
        if (dv[c-1]) held = ds[c-1];
        tests++;
        if (bus_s.out_valid !== dv[c-1] || bus_s.sum !== held) begin
          fails++;
          $display("FAIL n3_pair%0d: valid=%0b sum=%0d, expected %0b/%0d", c - 1, bus_s.out_valid, bus_s.sum, dv[c-1], held);
        end
      end
    end
    bus_s.in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_carry();
    test_random();
    test_latency3();
    test_exhaustive_n3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
